// File: rtl/order_panel_pkg.sv
// ----------------------------------------------------------------------------
// order_panel_pkg
// Shared types and colour constants for the order panel overlay.
//   slot_state_t : per-slot lifecycle (IDLE -> ACTIVE -> EXPIRED -> IDLE)
//   order_type_t : dish/sprite selector carried by each order
//   COLOR_*      : 12-bit RGB444 colours used by the pixel stage
// ----------------------------------------------------------------------------
package order_panel_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        EXPIRED = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        ORDER_TYPE_0 = 2'd0,
        ORDER_TYPE_1 = 2'd1,
        ORDER_TYPE_2 = 2'd2,
        ORDER_TYPE_3 = 2'd3
    } order_type_t;

    localparam logic [11:0] COLOR_BAR   = 12'h070;
    localparam logic [11:0] COLOR_FLASH = 12'hF00;
    localparam logic [11:0] COLOR_BG    = 12'h000;

endpackage

// File: rtl/order_slot.sv
// ----------------------------------------------------------------------------
// order_slot
// One order slot: lifecycle FSM, countdown timer (in time units) and a
// frame-tick prescaler that restarts at allocation.
// Ports:
//   pixel_clk_in, rst_n_in : clock / async active-low reset
//   frame_tick_in          : one-cycle pulse per frame
//   alloc_in               : take a new order (only acted on while IDLE)
//   time_in, type_in       : order time in units (0 treated as 1) and type
//   done_in                : order served (only acted on while ACTIVE)
//   idle_out, active_out   : state decodes
//   expired_out            : high for the single EXPIRED cycle
//   remaining_out          : remaining time units (time-bar width)
//   type_out               : order type held by the slot
// ----------------------------------------------------------------------------
module order_slot
    import order_panel_pkg::*;
#(
    parameter int TIME_W         = 5,
    parameter int TICKS_PER_UNIT = 60
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    input  logic              frame_tick_in,
    input  logic              alloc_in,
    input  logic [TIME_W-1:0] time_in,
    input  logic [1:0]        type_in,
    input  logic              done_in,
    output logic              idle_out,
    output logic              active_out,
    output logic              expired_out,
    output logic [TIME_W-1:0] remaining_out,
    output logic [1:0]        type_out
);

    localparam int PRE_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_UNIT - 1);

    slot_state_t       state_q, state_d;
    logic [TIME_W-1:0] timer_q, timer_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    order_type_t       type_q, type_d;

    // State register
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            timer_q <= '0;
            pre_q   <= '0;
            type_q  <= ORDER_TYPE_0;
        end else begin
            // NOTE: non-blocking so all registers update from pre-edge values.
            state_q <= state_d;
            timer_q <= timer_d;
            pre_q   <= pre_d;
            type_q  <= type_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: hold-value defaults first, so no path can infer a latch.
        state_d = state_q;
        timer_d = timer_q;
        pre_d   = pre_q;
        type_d  = type_q;
        unique case (state_q)
            IDLE: begin
                if (alloc_in) begin
                    state_d = ACTIVE;
                    timer_d = (time_in == '0) ? TIME_W'(1) : time_in;
                    pre_d   = '0;
                    type_d  = order_type_t'(type_in);
                end
            end
            ACTIVE: begin
                // Serving beats expiry when both land in the same cycle.
                if (done_in) begin
                    state_d = IDLE;
                    timer_d = '0;
                    pre_d   = '0;
                end else if (frame_tick_in) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d   = '0;
                        timer_d = timer_q - TIME_W'(1);
                        if (timer_q == TIME_W'(1)) begin
                            state_d = EXPIRED;
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            EXPIRED: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        idle_out      = (state_q == IDLE);
        active_out    = (state_q == ACTIVE);
        expired_out   = (state_q == EXPIRED);
        remaining_out = timer_q;
        type_out      = type_q;
    end

endmodule

// File: rtl/order_panel.sv
// ----------------------------------------------------------------------------
// order_panel
// Row of NUM_SLOTS order sprites with a countdown time bar under each.
// Orders are placed in the lowest free slot; each slot counts down on frame
// ticks and pulses expired_out when it runs out.
// Pixel pipeline: stage 0 decodes the pixel and registers the sprite ROM
// request, stage 1 is the ROM return, stage 2 registers pixel_out.
// Ports:
//   pixel_clk_in, rst_n_in          : clock / async active-low reset
//   frame_tick_in                   : one-cycle pulse per frame
//   x_in, y_in                      : panel origin
//   hcount_in, vcount_in            : current pixel
//   new_order_in/new_type_in/new_time_in : create an order
//   done_in, done_slot_in           : serve the order in a slot
//   sprite_addr_out, sprite_type_out: sprite ROM request
//   sprite_pix_in                   : ROM colour, one cycle after request
//   pixel_out                       : panel colour (COLOR_BG outside)
//   active_out, full_out, expired_out : slot status
// Build option: define ORDER_PANEL_FLASH_EN to flash the bar red/green
// every 8 frame ticks once 3 or fewer time units remain.
// ----------------------------------------------------------------------------
module order_panel
    import order_panel_pkg::*;
#(
    parameter  int NUM_SLOTS      = 4,
    parameter  int SPRITE_W       = 32,
    parameter  int SPRITE_H       = 32,
    parameter  int TIME_W         = 5,
    parameter  int TICKS_PER_UNIT = 60,
    parameter  int SLOT_GAP       = 8,
    parameter  int BAR_H          = 3,
    localparam int SLOT_W         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_n_in,
    input  logic                 frame_tick_in,
    input  logic [9:0]           x_in,
    input  logic [8:0]           y_in,
    input  logic [9:0]           hcount_in,
    input  logic [8:0]           vcount_in,
    input  logic                 new_order_in,
    input  logic [1:0]           new_type_in,
    input  logic [TIME_W-1:0]    new_time_in,
    input  logic                 done_in,
    input  logic [SLOT_W-1:0]    done_slot_in,
    output logic [11:0]          sprite_addr_out,
    output logic [1:0]           sprite_type_out,
    input  logic [11:0]          sprite_pix_in,
    output logic [11:0]          pixel_out,
    output logic [NUM_SLOTS-1:0] active_out,
    output logic                 full_out,
    output logic [NUM_SLOTS-1:0] expired_out
);

    localparam int PITCH = SPRITE_W + SLOT_GAP;

    logic [NUM_SLOTS-1:0] slot_idle, slot_active, slot_expired;
    logic [NUM_SLOTS-1:0] alloc_vec, done_vec;
    logic [NUM_SLOTS-1:0] in_sprite, in_bar;
    logic [TIME_W-1:0]    slot_rem  [NUM_SLOTS];
    logic [1:0]           slot_type [NUM_SLOTS];
    logic [15:0]          dx        [NUM_SLOTS];
    logic [15:0]          dy_sprite, dy_bar;

    // Isolate the lowest set bit of the idle mask: lowest free slot wins.
    // A slot freed this cycle is not IDLE yet, so it cannot be re-taken.
    assign alloc_vec = new_order_in ? (slot_idle & (~slot_idle + NUM_SLOTS'(1))) : '0;

    // Offsets are unsigned and wrap when the pixel lies before the region,
    // so a single "< size" test covers both bounds.
    assign dy_sprite = {7'd0, vcount_in} - {7'd0, y_in};
    assign dy_bar    = {7'd0, vcount_in} - ({7'd0, y_in} + 16'(SPRITE_H + 1));

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign done_vec[i] = done_in && (done_slot_in == SLOT_W'(i));
        assign dx[i]       = {6'd0, hcount_in} - ({6'd0, x_in} + 16'(i * PITCH));
        assign in_sprite[i] = slot_active[i] && (dx[i] < 16'(SPRITE_W)) &&
                              (dy_sprite < 16'(SPRITE_H));
        assign in_bar[i]    = slot_active[i] && (dy_bar < 16'(BAR_H)) &&
                              (dx[i] < 16'(slot_rem[i]));

        order_slot #(
            .TIME_W         (TIME_W),
            .TICKS_PER_UNIT (TICKS_PER_UNIT)
        ) u_slot (
            .pixel_clk_in  (pixel_clk_in),
            .rst_n_in      (rst_n_in),
            .frame_tick_in (frame_tick_in),
            .alloc_in      (alloc_vec[i]),
            .time_in       (new_time_in),
            .type_in       (new_type_in),
            .done_in       (done_vec[i]),
            .idle_out      (slot_idle[i]),
            .active_out    (slot_active[i]),
            .expired_out   (slot_expired[i]),
            .remaining_out (slot_rem[i]),
            .type_out      (slot_type[i])
        );
    end

    assign active_out  = slot_active;
    assign expired_out = slot_expired;
    assign full_out    = ~|slot_idle;

`ifdef ORDER_PANEL_FLASH_EN
    // Free-running frame-tick counter; bit 3 flips every 8 ticks.
    logic [3:0] flash_cnt_q;
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            flash_cnt_q <= '0;
        end else if (frame_tick_in) begin
            flash_cnt_q <= flash_cnt_q + 4'd1;
        end
    end
`endif

    // Stage 0: pick the slot under the pixel (lowest index wins).
    logic        sprite_hit_d, bar_hit_d;
    logic [11:0] addr_d, bar_color_d;
    logic [1:0]  type_d;

    always_comb begin
        sprite_hit_d = |in_sprite;
        bar_hit_d    = |in_bar;
        addr_d       = '0;
        type_d       = '0;
        bar_color_d  = COLOR_BAR;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (in_sprite[i]) begin
                addr_d = 12'(dx[i] + dy_sprite * 16'(SPRITE_W));
                type_d = slot_type[i];
            end
`ifdef ORDER_PANEL_FLASH_EN
            if (in_bar[i]) begin
                bar_color_d = (flash_cnt_q[3] && (32'(slot_rem[i]) <= 32'd3)) ?
                              COLOR_FLASH : COLOR_BAR;
            end
`endif
        end
    end

    // Stages 0-2: ROM request, hit flags delayed alongside the ROM, output.
    logic        sprite_hit_q1, sprite_hit_q2, bar_hit_q1, bar_hit_q2;
    logic [11:0] bar_color_q1, bar_color_q2;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sprite_addr_out <= '0;
            sprite_type_out <= '0;
            sprite_hit_q1   <= 1'b0;
            sprite_hit_q2   <= 1'b0;
            bar_hit_q1      <= 1'b0;
            bar_hit_q2      <= 1'b0;
            bar_color_q1    <= COLOR_BG;
            bar_color_q2    <= COLOR_BG;
            pixel_out       <= COLOR_BG;
        end else begin
            sprite_addr_out <= addr_d;
            sprite_type_out <= type_d;
            sprite_hit_q1   <= sprite_hit_d;
            sprite_hit_q2   <= sprite_hit_q1;
            bar_hit_q1      <= bar_hit_d;
            bar_hit_q2      <= bar_hit_q1;
            bar_color_q1    <= bar_color_d;
            bar_color_q2    <= bar_color_q1;
            pixel_out       <= sprite_hit_q2 ? sprite_pix_in :
                               bar_hit_q2    ? bar_color_q2  : COLOR_BG;
        end
    end

endmodule

// File: tb/tb_order_panel.sv
// ----------------------------------------------------------------------------
// tb_order_panel
// Directed scenarios followed by randomized traffic, checked against an
// order-level model: each order is (type, initial time, ticks aged) and its
// remaining time is time - age/TICKS_PER_UNIT; it expires when age reaches
// time*TICKS_PER_UNIT. A small behavioural ROM feeds sprite_pix_in.
// ----------------------------------------------------------------------------
module tb_order_panel;

    localparam int NS = 4, SW = 32, SH = 32, TW = 5, TPU = 60, GAP = 8, BARH = 3;
    localparam int PITCH = SW + GAP;
    localparam int X0 = 100, Y0 = 50;

    logic          clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0;
    logic [9:0]    x_in = 10'(X0), hcount = '0;
    logic [8:0]    y_in = 9'(Y0), vcount = '0;
    logic          new_order = 1'b0, done = 1'b0;
    logic [1:0]    new_type = '0, done_slot = '0;
    logic [TW-1:0] new_time = '0;
    logic [11:0]   sprite_addr, pixel;
    logic [1:0]    sprite_type;
    logic [11:0]   sprite_pix = '0;
    logic [NS-1:0] active, expired;
    logic          full;

    int n_checks = 0, n_errors = 0;

    // Order model: 0 = free, 1 = running, 2 = expiring this cycle
    int m_st[NS], m_t0[NS], m_age[NS], m_ty[NS];
    int tick_total;
    logic [11:0] pix_q[$];

    order_panel #(
        .NUM_SLOTS(NS), .SPRITE_W(SW), .SPRITE_H(SH), .TIME_W(TW),
        .TICKS_PER_UNIT(TPU), .SLOT_GAP(GAP), .BAR_H(BARH)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_n_in       (rst_n),
        .frame_tick_in  (frame_tick),
        .x_in           (x_in),
        .y_in           (y_in),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .new_order_in   (new_order),
        .new_type_in    (new_type),
        .new_time_in    (new_time),
        .done_in        (done),
        .done_slot_in   (done_slot),
        .sprite_addr_out(sprite_addr),
        .sprite_type_out(sprite_type),
        .sprite_pix_in  (sprite_pix),
        .pixel_out      (pixel),
        .active_out     (active),
        .full_out       (full),
        .expired_out    (expired)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [11:0] rom_fn(input logic [11:0] a, input logic [1:0] t);
        if (a == 12'd0) return 12'hABC;
        return 12'(a * 12'd7) ^ {t, 10'h2A5};
    endfunction

    // Synchronous sprite ROM: data one cycle after the request.
    always @(posedge clk) sprite_pix <= rom_fn(sprite_addr, sprite_type);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_rem(input int i);
        return m_t0[i] - m_age[i] / TPU;
    endfunction

    function automatic logic [NS-1:0] model_vec(input int s);
        logic [NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = (m_st[i] == s);
        return v;
    endfunction

    function automatic logic model_full();
        for (int i = 0; i < NS; i++) if (m_st[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [11:0] model_pixel(input int hh, input int vv, output bit hit,
                                                output int addr, output int ty);
        hit = 1'b0; addr = 0; ty = 0;
        for (int i = 0; i < NS; i++) begin
            int sx = X0 + i * PITCH;
            if (!hit && m_st[i] == 1 && hh >= sx && hh < sx + SW && vv >= Y0 && vv < Y0 + SH) begin
                hit = 1'b1; addr = (hh - sx) + (vv - Y0) * SW; ty = m_ty[i];
            end
        end
        if (hit) return rom_fn(12'(addr), 2'(ty));
        for (int i = 0; i < NS; i++) begin
            int sx = X0 + i * PITCH;
            if (m_st[i] == 1 && vv >= Y0 + SH + 1 && vv < Y0 + SH + 1 + BARH &&
                hh >= sx && hh < sx + m_rem(i)) begin
`ifdef ORDER_PANEL_FLASH_EN
                if (((tick_total / 8) % 2) == 1 && m_rem(i) <= 3) return 12'hF00;
`endif
                return 12'h070;
            end
        end
        return 12'h000;
    endfunction

    task automatic model_step(input bit no, input int ty, input int tm, input bit dn,
                              input int ds, input bit ft);
        int ai = -1;
        if (no) for (int i = 0; i < NS; i++) if (m_st[i] == 0 && ai < 0) ai = i;
        if (ft) tick_total++;
        for (int i = 0; i < NS; i++) begin
            if (m_st[i] == 2) begin
                m_st[i] = 0;
            end else if (m_st[i] == 1) begin
                if (dn && ds == i) m_st[i] = 0;
                else if (ft) begin
                    m_age[i]++;
                    if (m_age[i] == m_t0[i] * TPU) m_st[i] = 2;
                end
            end else if (i == ai) begin
                m_st[i] = 1; m_t0[i] = (tm == 0) ? 1 : tm; m_age[i] = 0; m_ty[i] = ty;
            end
        end
    endtask

    // One clock: drive at the falling edge, check at the next falling edge.
    task automatic cyc(input bit no, input int ty, input int tm, input bit dn,
                       input int ds, input bit ft, input int hh, input int vv);
        bit hit; int addr, ty_e; logic [11:0] p;
        new_order = no; new_type = 2'(ty); new_time = TW'(tm);
        done = dn; done_slot = 2'(ds); frame_tick = ft;
        hcount = 10'(hh); vcount = 9'(vv);
        p = model_pixel(hh, vv, hit, addr, ty_e);
        pix_q.push_back(p);
        model_step(no, ty, tm, dn, ds, ft);
        @(posedge clk);
        @(negedge clk);
        check("active", active, model_vec(1));
        check("expired", expired, model_vec(2));
        check("full", full, model_full());
        if (hit) begin
            check("addr", sprite_addr, addr);
            check("type", sprite_type, ty_e);
        end
        if (pix_q.size() == 3) check("pixel", pixel, pix_q.pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0; new_order = 1'b0; done = 1'b0; frame_tick = 1'b0;
        hcount = '0; vcount = '0;
        for (int i = 0; i < NS; i++) begin
            m_st[i] = 0; m_t0[i] = 0; m_age[i] = 0; m_ty[i] = 0;
        end
        tick_total = 0;
        pix_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst_pixel", pixel, 12'h000);
        check("rst_addr", sprite_addr, 0);
        check("rst_type", sprite_type, 0);
        check("rst_active", active, 0);
        check("rst_expired", expired, 0);
        check("rst_full", full, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int n; bit seen;
        bit no, dn, ft; int ty, tm, ds, hh, vv;

        // First order: type 2, time 5, bar 5 px wide one row below the sprite
        do_reset();
        cyc(1, 2, 5, 0, 0, 0, X0 + 4, Y0 + 33);
        check("first_active", active, 4'b0001);
        cyc(0, 0, 0, 0, 0, 0, X0 + 4, Y0 + 33);
        cyc(0, 0, 0, 0, 0, 0, X0 + 5, Y0 + 33);
        cyc(0, 0, 0, 0, 0, 0, X0 + 10, Y0 + 10);
        check("first_type", sprite_type, 2);
        check("bar_px4", pixel, 12'h070);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("bar_px5", pixel, 12'h000);

        // Time 2 expires after exactly 2*TPU frame ticks
        do_reset();
        cyc(1, 0, 2, 0, 0, 0, 0, 0);
        n = 0; seen = 1'b0;
        while (!seen && n < 400) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 0);
            n++;
            seen = expired[0];
        end
        check("expire_ticks", n, 120);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        check("expire_gone", {expired[0], active[0]}, 0);

        // Fill all slots; the fifth order is dropped
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1, k % 4, 3 + k, 0, 0, 0, 0, 0);
            if (k == 3) check("full_at4", full, 1);
        end
        check("full_after5", active, 4'hF);
        cyc(0, 0, 0, 0, 0, 0, X0 + 3 * PITCH + 5, Y0 + 5);
        check("slot3_type", sprite_type, 3);

        // Done + new order while full: slot freed, order dropped; then retaken
        cyc(1, 0, 9, 1, 1, 0, 0, 0);
        check("done_drop", active, 4'b1101);
        cyc(1, 2, 9, 0, 0, 0, 0, 0);
        check("realloc", active, 4'hF);
        cyc(0, 0, 0, 0, 0, 0, X0 + PITCH + 3, Y0 + 3);
        check("realloc_type", sprite_type, 2);

        // ROM colour at slot 1 origin appears two cycles later
        cyc(0, 0, 0, 0, 0, 0, X0 + PITCH, Y0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("rom_pixel", pixel, 12'hABC);

        // Reset with three orders running: outputs clear at once, no pulse
        cyc(0, 0, 0, 1, 3, 0, 0, 0);
        check("three_active", active, 4'b0111);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_active", active, 0);
        check("midrst_expired", expired, 0);
        check("midrst_full", full, 0);
        check("midrst_pixel", pixel, 12'h000);
        check("midrst_addr", sprite_addr, 0);
        @(negedge clk);
        check("midrst_no_pulse", expired, 0);
        do_reset();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            no = ($urandom_range(0, 7) == 0);
            ty = $urandom_range(0, 3);
            tm = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
            dn = ($urandom_range(0, 15) == 0);
            ds = $urandom_range(0, 3);
            ft = ($urandom_range(0, 3) != 0);
            hh = $urandom_range(X0 - 4, X0 + NS * PITCH + 4);
            vv = $urandom_range(Y0 - 2, Y0 + SH + 1 + BARH + 2);
            cyc(no, ty, tm, dn, ds, ft, hh, vv);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
